// File: rtl/branch_predictor_gshare.sv
// ID-stage branch predictor: saturating-counter pattern table (bimodal/gshare),
// global history register, direct-mapped BTB and saturating statistics.
module branch_predictor_gshare #(
  parameter int INDEX_WIDTH     = 3,
  parameter int COUNTER_WIDTH   = 2,
  parameter int HISTORY_WIDTH   = 3,
  parameter int GSHARE          = 0,
  parameter int BTB_INDEX_WIDTH = 3,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              lookup_pc,
  output logic                     predict_taken,
  output logic                     btb_hit,
  output logic [31:0]              predict_target,
  input  logic                     update_valid,
  input  logic [31:0]              update_pc,
  input  logic                     update_taken,
  input  logic                     update_predicted,
  input  logic [31:0]              update_target,
  output logic [HISTORY_WIDTH-1:0] ghr,
  output logic [STAT_WIDTH-1:0]    stat_branches,
  output logic [STAT_WIDTH-1:0]    stat_mispredicts
);

  localparam int PHT_N = 1 << INDEX_WIDTH;
  localparam int BTB_N = 1 << BTB_INDEX_WIDTH;
  localparam int TAG_W = 32 - BTB_INDEX_WIDTH - 2;

  localparam logic [COUNTER_WIDTH-1:0] CNT_INIT =
    COUNTER_WIDTH'((2 ** (COUNTER_WIDTH - 1)) - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0]    STAT_MAX = '1;

  logic [COUNTER_WIDTH-1:0] cnt_q [PHT_N];
  logic [COUNTER_WIDTH-1:0] cnt_d [PHT_N];
  logic                     bv_q  [BTB_N];
  logic                     bv_d  [BTB_N];
  logic [TAG_W-1:0]         btag_q [BTB_N];
  logic [TAG_W-1:0]         btag_d [BTB_N];
  logic [31:0]              btgt_q [BTB_N];
  logic [31:0]              btgt_d [BTB_N];

  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0]    sbr_q, sbr_d;
  logic [STAT_WIDTH-1:0]    smp_q, smp_d;

  logic [INDEX_WIDTH-1:0]     hist_mix;
  logic [INDEX_WIDTH-1:0]     l_idx;
  logic [INDEX_WIDTH-1:0]     u_idx;
  logic [BTB_INDEX_WIDTH-1:0] l_bidx;
  logic [BTB_INDEX_WIDTH-1:0] u_bidx;
  logic [TAG_W-1:0]           l_tag;
  logic [TAG_W-1:0]           u_tag;
  logic [COUNTER_WIDTH-1:0]   u_cnt;
  logic                       unused_pc_lsb;

  assign unused_pc_lsb = ^{lookup_pc[1:0], update_pc[1:0]};

  // History is zero-extended into the index; bimodal ignores it.
  assign hist_mix = (GSHARE != 0) ? INDEX_WIDTH'(ghr_q) : '0;

  assign l_idx  = lookup_pc[INDEX_WIDTH+1:2] ^ hist_mix;
  assign u_idx  = update_pc[INDEX_WIDTH+1:2] ^ hist_mix;
  assign l_bidx = lookup_pc[BTB_INDEX_WIDTH+1:2];
  assign u_bidx = update_pc[BTB_INDEX_WIDTH+1:2];
  assign l_tag  = lookup_pc[31:BTB_INDEX_WIDTH+2];
  assign u_tag  = update_pc[31:BTB_INDEX_WIDTH+2];
  assign u_cnt  = cnt_q[u_idx];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign predict_taken  = cnt_q[l_idx][COUNTER_WIDTH-1];
  assign btb_hit        = bv_q[l_bidx] && (btag_q[l_bidx] == l_tag);
  assign predict_target = btb_hit ? btgt_q[l_bidx] : '0;

  assign ghr              = ghr_q;
  assign stat_branches    = sbr_q;
  assign stat_mispredicts = smp_q;

  always_comb begin
    cnt_d  = cnt_q;
    bv_d   = bv_q;
    btag_d = btag_q;
    btgt_d = btgt_q;
    ghr_d  = ghr_q;
    sbr_d  = sbr_q;
    smp_d  = smp_q;
    if (update_valid) begin
      if (update_taken) begin
        if (u_cnt != CNT_MAX) begin
          cnt_d[u_idx] = u_cnt + COUNTER_WIDTH'(1);
        end
        bv_d[u_bidx]   = 1'b1;
        btag_d[u_bidx] = u_tag;
        btgt_d[u_bidx] = update_target;
      end else if (u_cnt != '0) begin
        cnt_d[u_idx] = u_cnt - COUNTER_WIDTH'(1);
      end
      ghr_d = (ghr_q << 1) | HISTORY_WIDTH'(update_taken);
      if (sbr_q != STAT_MAX) begin
        sbr_d = sbr_q + STAT_WIDTH'(1);
      end
      if ((update_predicted != update_taken) && (smp_q != STAT_MAX)) begin
        smp_d = smp_q + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
      for (int i = 0; i < BTB_N; i++) begin
        bv_q[i]   <= 1'b0;
        btag_q[i] <= '0;
        btgt_q[i] <= '0;
      end
      ghr_q <= '0;
      sbr_q <= '0;
      smp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bv_q   <= bv_d;
      btag_q <= btag_d;
      btgt_q <= btgt_d;
      ghr_q  <= ghr_d;
      sbr_q  <= sbr_d;
      smp_q  <= smp_d;
    end
  end

endmodule
